// File: rtl/config_loader_if.sv
// =============================================================================
// Module      : config_loader_if
// Description : Bitstream word channel, chain drive/return and status bundle
//               for config_loader.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface config_loader_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              chain_data;
    logic              chain_enable;
    logic              chain_return;
    logic              busy;
    logic              done;
    logic              error;

    // slave = the loader; master = host plus the chain it drives
    modport slave (
        input  start, word_data, word_valid, chain_return,
        output word_ready, chain_data, chain_enable, busy, done, error
    );

    modport master (
        output start, word_data, word_valid, chain_return,
        input  word_ready, chain_data, chain_enable, busy, done, error
    );
endinterface

`default_nettype wire

// File: rtl/config_loader.sv
// =============================================================================
// Module      : config_loader
// Description : Serializes a 32-bit word bitstream LSB-first onto an IO-column
//               config shift chain. Optional readback verify via macro
//               CONFIG_READBACK_EN (rotate chain once, compare CRC-16-CCITT).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module config_loader #(
    parameter int CHAIN_LEN = 320,
    parameter int WORD_W    = 32
) (
    input  wire logic      clock,
    input  wire logic      config_nreset,
    config_loader_if.slave bus
);
    localparam int              c_BW  = $clog2(CHAIN_LEN + 1);
    localparam int              c_CW  = $clog2(WORD_W + 1);
    localparam logic [c_BW-1:0] c_LEN = c_BW'(CHAIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DONE   = 3'd2
`ifdef CONFIG_READBACK_EN
        ,
        S_VERIFY = 3'd3,
        S_FAIL   = 3'd4
`endif
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [WORD_W-1:0] r_buf, w_buf_nxt;
    logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
    logic [c_BW-1:0]   r_bitcnt, w_bitcnt_nxt;
    logic              r_data, w_data_nxt;
    logic              r_en, w_en_nxt;
    logic              w_ready;
    logic [c_BW-1:0]   w_owed;
    logic [c_CW-1:0]   w_take;

`ifdef CONFIG_READBACK_EN
    localparam logic [15:0] c_CRC_POLY = 16'h1021;
    localparam logic [15:0] c_CRC_INIT = 16'hFFFF;

    logic [15:0] r_crc_load, w_crc_load_nxt;
    logic [15:0] r_crc_ret, w_crc_ret_nxt;
    logic        r_error, w_error_nxt;

    function automatic logic [15:0] f_crc_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? c_CRC_POLY : 16'h0000);
    endfunction
`else
    logic w_unused_return;
    assign w_unused_return = bus.chain_return;
`endif

    // r_cnt holds bits still waiting in r_buf; r_bitcnt counts bits already presented
    assign w_owed = c_LEN - r_bitcnt;
    assign w_take = (32'(w_owed) >= 32'(WORD_W)) ? c_CW'(WORD_W) : c_CW'(w_owed);

    always_comb begin
        w_state_nxt  = r_state;
        w_buf_nxt    = r_buf;
        w_cnt_nxt    = r_cnt;
        w_bitcnt_nxt = r_bitcnt;
        w_data_nxt   = 1'b0;
        w_en_nxt     = 1'b0;
        w_ready      = 1'b0;
`ifdef CONFIG_READBACK_EN
        w_crc_load_nxt = r_crc_load;
        w_crc_ret_nxt  = r_crc_ret;
        w_error_nxt    = r_error;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt  = S_LOAD;
                    w_cnt_nxt    = '0;
                    w_bitcnt_nxt = '0;
`ifdef CONFIG_READBACK_EN
                    w_crc_load_nxt = c_CRC_INIT;
                    w_crc_ret_nxt  = c_CRC_INIT;
                    w_error_nxt    = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                w_ready = (r_cnt == '0) && (r_bitcnt != c_LEN);
`ifdef CONFIG_READBACK_EN
                if (r_en) begin
                    w_crc_load_nxt = f_crc_step(r_crc_load, r_data);
                end
`endif
                if (r_cnt != '0) begin
                    w_data_nxt   = r_buf[0];
                    w_en_nxt     = 1'b1;
                    w_buf_nxt    = r_buf >> 1;
                    w_cnt_nxt    = r_cnt - 1'b1;
                    w_bitcnt_nxt = r_bitcnt + 1'b1;
                end else if (w_ready && bus.word_valid) begin
                    // bit 0 goes straight to the output register so words stream gap-free
                    w_data_nxt   = bus.word_data[0];
                    w_en_nxt     = 1'b1;
                    w_buf_nxt    = bus.word_data >> 1;
                    w_cnt_nxt    = w_take - 1'b1;
                    w_bitcnt_nxt = r_bitcnt + 1'b1;
                end else if (r_bitcnt == c_LEN) begin
`ifdef CONFIG_READBACK_EN
                    w_state_nxt  = S_VERIFY;
                    w_en_nxt     = 1'b1;
                    w_bitcnt_nxt = '0;
`else
                    w_state_nxt  = S_DONE;
`endif
                end
            end
`ifdef CONFIG_READBACK_EN
            S_VERIFY: begin
                w_en_nxt      = 1'b1;
                w_crc_ret_nxt = f_crc_step(r_crc_ret, bus.chain_return);
                w_bitcnt_nxt  = r_bitcnt + 1'b1;
                if (r_bitcnt == c_LEN - 1'b1) begin
                    w_en_nxt = 1'b0;
                    if (w_crc_ret_nxt == r_crc_load) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_FAIL;
                        w_error_nxt = 1'b1;
                    end
                end
            end
            S_FAIL: begin
                w_state_nxt = S_IDLE;
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge config_nreset) begin
        if (!config_nreset) begin
            r_state  <= S_IDLE;
            r_buf    <= '0;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_data   <= 1'b0;
            r_en     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_buf    <= w_buf_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_data   <= w_data_nxt;
            r_en     <= w_en_nxt;
        end
    end

`ifdef CONFIG_READBACK_EN
    always_ff @(posedge clock or negedge config_nreset) begin
        if (!config_nreset) begin
            r_crc_load <= c_CRC_INIT;
            r_crc_ret  <= c_CRC_INIT;
            r_error    <= 1'b0;
        end else begin
            r_crc_load <= w_crc_load_nxt;
            r_crc_ret  <= w_crc_ret_nxt;
            r_error    <= w_error_nxt;
        end
    end

    // Verify closes the ring combinationally so its length stays CHAIN_LEN
    assign bus.chain_data = (r_state == S_VERIFY) ? bus.chain_return : r_data;
    assign bus.busy       = (r_state == S_LOAD) || (r_state == S_VERIFY);
    assign bus.error      = r_error;
`else
    assign bus.chain_data = r_data;
    assign bus.busy       = (r_state == S_LOAD);
    assign bus.error      = 1'b0;
`endif

    assign bus.word_ready   = w_ready;
    assign bus.chain_enable = r_en;
    assign bus.done         = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_config_loader.sv
// =============================================================================
// Module      : tb_config_loader
// Description : Randomized scoreboard bench for config_loader with a behavioural
//               shift-chain model; honours CONFIG_READBACK_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_config_loader;
    localparam int CL = 40;
    localparam int WW = 32;
`ifdef CONFIG_READBACK_EN
    localparam int DONE_GAP = CL + 1;
`else
    localparam int DONE_GAP = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    config_loader_if #(.WORD_W(WW)) bus ();

    config_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .clock         (clk),
        .config_nreset (rst_n),
        .bus           (bus)
    );

    // Behavioural chain: shifts in at index 0, returns from the far end
    logic [CL-1:0] chain = '0;
    logic          flip  = 1'b0;
    always @(posedge clk) if (bus.chain_enable) chain <= {chain[CL-2:0], bus.chain_data};
    assign bus.chain_return = chain[CL-1] ^ flip;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    bit            exp_q[$];
    logic [CL-1:0] exp_img;
    int            pushed;
    logic [31:0]   words[$];
    int            load_id = 0;

    // Monitor: every enabled load-phase chain bit must be the next expected bit
    int mon_id = 0, mon_bits = 0, last_bit_cyc = 0;
    always @(negedge clk) begin
        if (mon_id != load_id) begin
            mon_id   = load_id;
            mon_bits = 0;
        end
        if (bus.chain_enable && mon_bits < CL) begin
            if (exp_q.size() == 0) begin
                chk("bit_unexpected", 64'(bus.chain_enable), 64'd0);
            end else begin
                chk($sformatf("bit%0d", mon_bits), 64'(bus.chain_data), 64'(exp_q.pop_front()));
            end
            mon_bits++;
            last_bit_cyc = cyc;
        end
        if (bus.done) chk("done_gap", 64'(cyc - last_bit_cyc), 64'(DONE_GAP));
    end

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_ready"},  64'(bus.word_ready),   64'd0);
        chk({pfx, "_data"},   64'(bus.chain_data),   64'd0);
        chk({pfx, "_enable"}, 64'(bus.chain_enable), 64'd0);
        chk({pfx, "_busy"},   64'(bus.busy),         64'd0);
        chk({pfx, "_done"},   64'(bus.done),         64'd0);
        chk({pfx, "_error"},  64'(bus.error),        64'd0);
    endtask

    // mode: 0 valid held, 1 valid every other cycle, 2 random valid
    task automatic run_load(input int mode, input bit inject, input int reset_at, input bit extra_start,
                            input int exp_accepts);
        int sc, base, acc, wi;
        bit got_done, got_err, ready_late, fin, v;
        logic [31:0] cur;
        acc = 0; wi = 0; got_done = 0; got_err = 0; ready_late = 0; fin = 0;
        exp_q.delete();
        pushed  = 0;
        exp_img = '0;
        load_id++;
        cur = (words.size() > 0) ? words[0] : $urandom();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        base = cyc - 1;
        for (int n = 0; n < 4 * CL + 100 && !fin; n++) begin
            @(negedge clk);
            sc = cyc - base;
            if (reset_at > 0 && mon_bits >= reset_at) begin
                rst_n = 1'b0;
                #1 chk_all_zero("midrst");
                bus.word_valid = 1'b0;
                bus.start      = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            bus.start = extra_start && (sc == 3 || sc == CL / 2);
            flip      = inject && (sc == CL + 10);
            if (sc == 1) begin
                chk("c1_busy",  64'(bus.busy),  64'd1);
                chk("c1_error", 64'(bus.error), 64'd0);
            end
            if (bus.done) begin
                got_done = 1;
                fin      = 1;
                chk("done_busy", 64'(bus.busy), 64'd0);
                if (mode == 0) chk("done_cycle", 64'(sc), 64'(CL + 1 + DONE_GAP));
            end
            if (bus.error) begin
                got_err = 1;
                fin     = 1;
                chk("err_busy", 64'(bus.busy), 64'd0);
                chk("err_cycle", 64'(sc), 64'(2 * CL + 2));
            end
            if (fin) begin
                bus.word_valid = 1'b0;
            end else begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (sc % 2) == 0;
                    default: v = $urandom_range(0, 3) != 0;
                endcase
                bus.word_valid = v;
                bus.word_data  = cur;
                #1;
                if (pushed == CL && bus.word_ready) ready_late = 1;
                if (v && bus.word_ready) begin
                    for (int b = 0; b < WW; b++) begin
                        if (pushed < CL) begin
                            exp_q.push_back(cur[b]);
                            exp_img[CL-1-pushed] = cur[b];
                            pushed++;
                        end
                    end
                    acc++;
                    wi++;
                    cur = (wi < words.size()) ? words[wi] : $urandom();
                end
            end
        end
        bus.start = 1'b0;
        flip      = 1'b0;
        chk("finished", 64'(fin), 64'd1);
        chk("got_done", 64'(got_done), 64'(!inject));
        chk("got_error", 64'(got_err), 64'(inject));
        chk("ready_after_last", 64'(ready_late), 64'd0);
        if (exp_accepts > 0) chk("accepts", 64'(acc), 64'(exp_accepts));
        if (got_done) begin
            chk("chain_image", 64'(chain), 64'(exp_img));
            chk("bits_left", 64'(exp_q.size()), 64'd0);
        end
        @(negedge clk);
        chk("after_busy", 64'(bus.busy), 64'd0);
        chk("after_done", 64'(bus.done), 64'd0);
    endtask

    initial begin
        int hi;
        bus.start      = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_data  = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.chain_enable || bus.busy) hi++;
        end
        chk("idle_quiet", 64'(hi), 64'd0);

        words = '{32'hA5A5A5A5, 32'h000000C3};
        run_load(0, 1'b0, 0, 1'b0, 2);
        words.delete();

        run_load(1, 1'b0, 0, 1'b0, 0);
        repeat (3) run_load(2, 1'b0, 0, 1'b0, 0);

`ifdef CONFIG_READBACK_EN
        run_load(0, 1'b1, 0, 1'b0, 0);
        chk("error_sticky", 64'(bus.error), 64'd1);
        run_load(2, 1'b0, 0, 1'b0, 0);
`endif

        run_load(0, 1'b0, 17, 1'b0, 0);
        chk_all_zero("post_rst");
        run_load(0, 1'b0, 0, 1'b1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
